// File: rtl/sseg_to_hex_capture.sv
// sseg_to_hex_capture: seven-segment bus readback monitor
//
// Watches a time-multiplexed, active-low seven-segment display bus and
// rebuilds the hex value and decimal point shown on each digit position.
// Both inputs are synchronized and must stay stable for STABLE_CYCLES
// samples before one capture is taken.
//
// Optional feature: define SSEG_CAP_ERRCNT_EN to build the saturating
// undecodable-capture counter on err_cnt. Without it, err_cnt is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   an         digit enables, active-low, one-hot-low while a digit is driven
//   sseg       segments, active-low; [6:0] = g..a, [7] = dp (raw level)
//   hex_out    decoded digit i in hex_out[4i+3:4i]
//   dp_out     captured sseg[7] level per digit
//   valid_out  digit i captured at least once since reset
//   err_out    last capture of digit i was an undecodable pattern
//   upd        one-cycle pulse on every capture
//   upd_idx    index of the digit captured with upd
//   err_cnt    saturating count of undecodable captures
module sseg_to_hex_capture #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [7:0]            sseg,
    output logic [4*N_DIGITS-1:0] hex_out,
    output logic [N_DIGITS-1:0]   dp_out,
    output logic [N_DIGITS-1:0]   valid_out,
    output logic [N_DIGITS-1:0]   err_out,
    output logic                  upd,
    output logic [2:0]            upd_idx,
    output logic [7:0]            err_cnt
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

    logic [N_DIGITS-1:0] r_an_s1, r_an_s2, r_an_prev;
    logic [7:0]          r_sseg_s1, r_sseg_s2, r_sseg_prev;
    logic [CW-1:0]       r_cnt;
    logic                r_done;

    logic [N_DIGITS-1:0] w_low;
    logic                w_same, w_onehot, w_fire, w_ok;
    logic [2:0]          w_idx;
    logic [3:0]          w_hex;

    // Bit 4 flags a recognised pattern, bits 3:0 carry the value.
    function automatic logic [4:0] dec(input logic [6:0] s);
        case (s)
            7'h40:   dec = 5'h10;
            7'h79:   dec = 5'h11;
            7'h24:   dec = 5'h12;
            7'h30:   dec = 5'h13;
            7'h19:   dec = 5'h14;
            7'h12:   dec = 5'h15;
            7'h02:   dec = 5'h16;
            7'h78:   dec = 5'h17;
            7'h00:   dec = 5'h18;
            7'h10:   dec = 5'h19;
            7'h20:   dec = 5'h1A;
            7'h03:   dec = 5'h1B;
            7'h46:   dec = 5'h1C;
            7'h21:   dec = 5'h1D;
            7'h06:   dec = 5'h1E;
            7'h0E:   dec = 5'h1F;
            default: dec = 5'h00;
        endcase
    endfunction

    always_comb begin
        w_same   = (r_an_s2 == r_an_prev) && (r_sseg_s2 == r_sseg_prev);
        w_low    = ~r_an_prev;
        w_onehot = (|w_low) && !(|(w_low & (w_low - N_DIGITS'(1))));
        w_idx    = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (w_low[i]) w_idx = 3'(i);
        // r_done blocks repeat captures while the counter sits saturated;
        // the capture uses the previous-stage sample, which is the stable one.
        w_fire       = (r_cnt == STABLE) && !r_done && w_onehot;
        {w_ok, w_hex} = dec(r_sseg_prev[6:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_s1     <= '1;
            r_an_s2     <= '1;
            r_an_prev   <= '1;
            r_sseg_s1   <= '1;
            r_sseg_s2   <= '1;
            r_sseg_prev <= '1;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            hex_out     <= '0;
            dp_out      <= '1;
            valid_out   <= '0;
            err_out     <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
        end else begin
            r_an_s1     <= an;
            r_an_s2     <= r_an_s1;
            r_an_prev   <= r_an_s2;
            r_sseg_s1   <= sseg;
            r_sseg_s2   <= r_sseg_s1;
            r_sseg_prev <= r_sseg_s2;
            r_cnt       <= !w_same ? CW'(1) : (r_cnt == STABLE ? r_cnt : r_cnt + CW'(1));
            r_done      <= w_same && (r_cnt == STABLE);
            upd         <= w_fire;
            if (w_fire) begin
                upd_idx          <= w_idx;
                dp_out[w_idx]    <= r_sseg_prev[7];
                valid_out[w_idx] <= 1'b1;
                err_out[w_idx]   <= !w_ok;
                if (w_ok) hex_out[4*int'(w_idx) +: 4] <= w_hex;
            end
        end
    end

`ifdef SSEG_CAP_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err_cnt <= '0;
        else if (w_fire && !w_ok && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule
